instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage upstream of the multicycle control unit.
- Owns the PC: issues a read to instruction memory, waits the fixed memory latency, latches the word into IR and advances PC by 4.
- Presents decoded instruction fields (OPCODE, rs, rt, rd, funct, imm16) with a one-cycle valid pulse. The control unit consumes the pulse instead of counting wait cycles itself.
- Also accepts a branch/jump PC load.

Parameters:
- ADDR_W, 32, PC / memory address width.
- MEM_LAT, 3, memory read latency in cycles; legal range 1..7.
- RESET_PC, 32'h0000_0000, PC value after reset; low 2 bits must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_req  in  1  level request for the next instruction; held high until instr_valid.
- flush  in  1  abort any fetch in progress.
- pc_load  in  1  load PC from pc_target.
- pc_target  in  ADDR_W  new PC value.
- mem_rdata  in  32  instruction memory read data.
- mem_addr  out  ADDR_W  memory address; always equals PC.
- mem_rd  out  1  read strobe; high while in FETCH.
- pc_out  out  ADDR_W  current PC.
- IR  out  32  latched instruction.
- OPCODE  out  6  IR[31:26].
- RS  out  5  IR[25:21].
- RT  out  5  IR[20:16].
- RD  out  5  IR[15:11].
- FUNCT  out  6  IR[5:0].
- IMM16  out  16  IR[15:0].
- instr_valid  out  1  one-cycle pulse: IR holds a new instruction.
- busy  out  1  high in FETCH.
- addr_err  out  1  one-cycle pulse: pc_target was misaligned.

Behaviour:
- Reset (async, any state):
  - State IDLE; PC = RESET_PC; IR = 0; counter = 0.
  - instr_valid, busy, mem_rd, addr_err = 0.
  - Pending-load register cleared.
  - Field outputs follow IR, so all are 0.
- States: IDLE, FETCH, DONE.
- IDLE:
  - pc_load=1 → PC <= {pc_target[ADDR_W-1:2],2'b00}; stay IDLE; fetch_req ignored that edge. pc_load has priority.
  - else fetch_req=1 and flush=0 → FETCH, cnt <= 0.
- FETCH:
  - mem_rd=1 and busy=1; mem_addr stable at PC.
  - Each edge: cnt <= cnt+1.
  - On the edge where cnt==MEM_LAT-1:
    - IR <= mem_rdata.
    - PC <= pending target if a load is pending (pending cleared), else PC+4, wrapping modulo 2^ADDR_W.
    - state → DONE.
  - pc_load during FETCH: target latched as pending and applied at completion in place of PC+4. Last load wins. addr_err is still evaluated immediately.
  - flush=1: → IDLE, cnt <= 0. IR and PC unchanged; pending load discarded. mem_rd drops the next cycle.
- DONE:
  - instr_valid=1 for exactly this cycle.
  - Next edge: fetch_req=1 and flush=0 → FETCH with cnt=0 (back-to-back, no IDLE bubble); else → IDLE.
  - pc_load in DONE is treated as in IDLE and takes priority over a refetch: PC loads, next state IDLE.
- Latency: fetch_req sampled at edge E0 → IR updated at edge E(MEM_LAT) → instr_valid high between E(MEM_LAT) and E(MEM_LAT+1).
- Back-to-back throughput: one instruction per MEM_LAT+1 cycles.
- addr_err: registered pulse, high the cycle after any edge where pc_load=1 and pc_target[1:0]!=0. The load still proceeds with the low bits forced to 0.
- Simultaneous flush and pc_load in FETCH: flush aborts the fetch, then pc_load applies directly to PC (not pending).
- IR holds its value outside completion edges; field outputs are purely combinational slices of IR.
- The block never writes memory.

Test Plan:
- Reset, MEM_LAT=3, then fetch_req held high → mem_addr=0x0 for 3 cycles; IR=mem_rdata (0x012A4020) at E3; OPCODE=0, RS=9, RT=10, RD=8, FUNCT=0x20; instr_valid one cycle; PC=0x4.
- fetch_req kept high for 3 fetches → instr_valid pulses every 4 cycles; PC sequence 0x4, 0x8, 0xC; no IDLE cycle between fetches.
- pc_load=1, pc_target=0x100 pulsed mid-FETCH → current IR still captured; PC=0x100, not PC+4; next mem_addr=0x100.
- pc_target=0x103 loaded in IDLE → PC=0x100; addr_err high exactly one cycle.
- flush asserted at cnt=1 → state IDLE; IR and PC unchanged; no instr_valid; mem_rd low next cycle.
- reset asserted mid-FETCH, asynchronously between edges → outputs cleared immediately; PC=RESET_PC; after release, a fetch restarts from RESET_PC. Wrap-around check: PC=0xFFFF_FFFC → PC=0x0 after fetch.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, reads instruction memory with a fixed latency and presents IR fields with a valid pulse.
module instr_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int MEM_LAT = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              flush,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_target,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       IR,
    output logic [5:0]        OPCODE,
    output logic [4:0]        RS,
    output logic [4:0]        RT,
    output logic [4:0]        RD,
    output logic [5:0]        FUNCT,
    output logic [15:0]       IMM16,
    output logic              instr_valid,
    output logic              busy,
    output logic              addr_err
);
    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t            state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] pc_q, pend_pc_q;
    logic              pend_q;
    logic [31:0]       ir_q;
    logic              addr_err_q;
    logic [ADDR_W-1:0] load_pc_d, next_pc_d;
    logic              last_d;
    assign load_pc_d = {pc_target[ADDR_W-1:2], 2'b00};
    // a load arriving on the completion edge itself is the latest one, so it wins over any pending target
    assign next_pc_d = pc_load ? load_pc_d : pend_q ? pend_pc_q : pc_q + ADDR_W'(4);
    assign last_d    = cnt_q == 3'(MEM_LAT - 1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            pend_q     <= 1'b0;
            ir_q       <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= pc_load && (pc_target[1:0] != 2'b00);
            case (state_q)
                IDLE: begin
                    if (pc_load) pc_q <= load_pc_d;
                    else if (fetch_req && !flush) begin
                        state_q <= FETCH;
                        cnt_q   <= '0;
                    end
                end
                FETCH: begin
                    if (flush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                        if (pc_load) pc_q <= load_pc_d;
                    end else if (last_d) begin
                        state_q <= DONE;
                        cnt_q   <= cnt_q + 3'd1;
                        ir_q    <= mem_rdata;
                        pc_q    <= next_pc_d;
                        pend_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                        if (pc_load) begin
                            pend_q    <= 1'b1;
                            pend_pc_q <= load_pc_d;
                        end
                    end
                end
                DONE: begin
                    if (pc_load) begin
                        pc_q    <= load_pc_d;
                        state_q <= IDLE;
                    end else if (fetch_req && !flush) begin
                        state_q <= FETCH;
                        cnt_q   <= '0;
                    end else state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign mem_addr    = pc_q;
    assign pc_out      = pc_q;
    assign mem_rd      = state_q == FETCH;
    assign busy        = state_q == FETCH;
    assign instr_valid = state_q == DONE;
    assign addr_err    = addr_err_q;
    assign IR          = ir_q;
    assign OPCODE      = ir_q[31:26];
    assign RS          = ir_q[25:21];
    assign RT          = ir_q[20:16];
    assign RD          = ir_q[15:11];
    assign FUNCT       = ir_q[5:0];
    assign IMM16       = ir_q[15:0];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed stimulus with a queue scoreboard checked on every instr_valid pulse.
module tb_instr_fetch_unit;
    logic        clk, reset, fetch_req, flush, pc_load;
    logic [31:0] pc_target, mem_rdata, mem_addr, pc_out, IR;
    logic        mem_rd, instr_valid, busy, addr_err;
    logic [5:0]  OPCODE, FUNCT;
    logic [4:0]  RS, RT, RD;
    logic [15:0] IMM16;
    int          errors = 0, checks = 0;
    logic [63:0] exp_q[$];

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .flush(flush),
        .pc_load(pc_load), .pc_target(pc_target), .mem_rdata(mem_rdata),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .pc_out(pc_out), .IR(IR),
        .OPCODE(OPCODE), .RS(RS), .RT(RT), .RD(RD), .FUNCT(FUNCT), .IMM16(IMM16),
        .instr_valid(instr_valid), .busy(busy), .addr_err(addr_err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // memory image: address 0 holds add $8,$9,$10, everything else {addr, ~addr}
    assign mem_rdata = (mem_addr == 32'h0) ? 32'h012A4020 : {mem_addr[15:0], ~mem_addr[15:0]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (instr_valid) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_valid: IR=0x%08h pc=0x%08h with no fetch outstanding", IR, pc_out);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_ir", IR, e[63:32]);
                chk("sb_pc", pc_out, e[31:0]);
            end
        end
    end

    initial begin
        reset = 1; fetch_req = 0; flush = 0; pc_load = 0; pc_target = 0;
        #12 reset = 0;
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ir", IR, 32'h0);
        chk("rst_flags", {instr_valid, busy, mem_rd, addr_err}, 0);
        tick(1);
        fetch_req = 1;
        exp_q.push_back({32'h012A4020, 32'h4});
        tick(1);
        chk("f0_rd_busy", {mem_rd, busy}, 2'b11);
        chk("f0_addr", mem_addr, 32'h0);
        tick(2);
        chk("f0_addr_stable", mem_addr, 32'h0);
        chk("f0_no_valid_early", instr_valid, 0);
        tick(1);
        chk("f0_valid", instr_valid, 1);
        chk("f0_opcode", OPCODE, 0);
        chk("f0_rs", RS, 9);
        chk("f0_rt", RT, 10);
        chk("f0_rd", RD, 8);
        chk("f0_funct", FUNCT, 32'h20);
        chk("f0_imm16", IMM16, 32'h4020);
        exp_q.push_back({32'h0004FFFB, 32'h8});
        exp_q.push_back({32'h0008FFF7, 32'hC});
        tick(1);
        chk("b2b_no_bubble", {busy, instr_valid}, 2'b10);
        chk("b2b_addr", mem_addr, 32'h4);
        tick(3);
        chk("b2b_valid2", instr_valid, 1);
        chk("b2b_pc2", pc_out, 32'h8);
        tick(4);
        chk("b2b_valid3", instr_valid, 1);
        chk("b2b_pc3", pc_out, 32'hC);
        fetch_req = 0;
        tick(1);
        chk("idle_after_b2b", busy, 0);
        fetch_req = 1;
        exp_q.push_back({32'h000CFFF3, 32'h100});
        tick(1);
        pc_load = 1; pc_target = 32'h100;
        tick(1);
        pc_load = 0;
        chk("ld_addr_hold", mem_addr, 32'hC);
        tick(2);
        chk("ld_valid", instr_valid, 1);
        chk("ld_next_addr", mem_addr, 32'h100);
        fetch_req = 0;
        tick(1);
        pc_load = 1; pc_target = 32'h103;
        tick(1);
        pc_load = 0;
        chk("mis_pc", pc_out, 32'h100);
        chk("mis_err", addr_err, 1);
        tick(1);
        chk("mis_err_pulse", addr_err, 0);
        fetch_req = 1;
        tick(2);
        flush = 1; fetch_req = 0;
        tick(1);
        flush = 0;
        chk("fl_flags", {mem_rd, busy, instr_valid}, 0);
        chk("fl_pc", pc_out, 32'h100);
        chk("fl_ir", IR, 32'h000CFFF3);
        fetch_req = 1;
        tick(1);
        #2 reset = 1;
        #1;
        chk("ar_pc", pc_out, 32'h0);
        chk("ar_ir", IR, 32'h0);
        chk("ar_flags", {mem_rd, busy, instr_valid, addr_err}, 0);
        #2 reset = 0;
        exp_q.push_back({32'h012A4020, 32'h4});
        tick(1);
        chk("ar_restart", {busy, mem_addr[30:0]}, 32'h80000000);
        tick(3);
        chk("ar_valid", instr_valid, 1);
        fetch_req = 0;
        tick(1);
        pc_load = 1; pc_target = 32'hFFFFFFFC;
        tick(1);
        pc_load = 0;
        chk("wr_pc", pc_out, 32'hFFFFFFFC);
        fetch_req = 1;
        exp_q.push_back({32'hFFFC0003, 32'h0});
        tick(4);
        chk("wr_valid", instr_valid, 1);
        chk("wr_pc_wrap", pc_out, 32'h0);
        fetch_req = 0;
        tick(1);
        fetch_req = 1;
        tick(1);
        flush = 1; pc_load = 1; pc_target = 32'h200; fetch_req = 0;
        tick(1);
        flush = 0; pc_load = 0;
        chk("flld_pc", pc_out, 32'h200);
        chk("flld_busy", busy, 0);
        fetch_req = 1;
        exp_q.push_back({32'h0200FDFF, 32'h204});
        tick(4);
        chk("flld_valid", instr_valid, 1);
        fetch_req = 0;
        tick(3);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
